// File: rtl/uart_tx_byte_if.sv
// uart_tx_byte_if
//   Byte handshake and serial output bundle of the UART byte transmitter.
//
//   Signals:
//     D      byte offered by the upstream serializer
//     valid  D holds a byte to send
//     ready  transmitter can accept a byte this cycle
//     tx     serial line, idles high
//     busy   frame in progress
//     done   one-cycle pulse when a frame's stop bit completes
//
//   Handshake: a byte moves on the rising edge where valid && ready are both
//   high. valid seen while ready is low is ignored (nothing is buffered), and
//   D only has to be stable on that accepting edge.
//
//   Modports:
//     master  the upstream side (drives D/valid, observes everything else)
//     slave   the transmitter itself
interface uart_tx_byte_if #(
    parameter int DATA_SIZE = 8
);
    logic [DATA_SIZE-1:0] D;
    logic                 valid;
    logic                 ready;
    logic                 tx;
    logic                 busy;
    logic                 done;

    modport master (
        output D, valid,
        input  ready, tx, busy, done
    );

    modport slave (
        input  D, valid,
        output ready, tx, busy, done
    );
endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte
//   Byte-wide UART transmitter. Takes one DATA_SIZE-bit byte per valid/ready
//   handshake and sends it on tx as start bit, data bits LSB first, optional
//   even-parity bit, stop bit. ready/done pace the upstream word-to-byte
//   serializer so consecutive bytes leave as back-to-back frames with one
//   idle-high cycle between them.
//
//   Parameters:
//     DATA_SIZE     data bits per frame (default 8)
//     CLKS_PER_BIT  clk cycles per UART bit (default 868, >= 2)
//
//   Ports:
//     clk        system clock, rising edge
//     rst        synchronous active-high reset
//     bus        uart_tx_byte_if.slave: D, valid, ready, tx, busy, done
//     dbg_state  current FSM state encoding (IDLE=0 START=1 DATA=2
//                PARITY=3 STOP=4)
//
//   Build option:
//     UART_TX_PARITY_EN  when defined, an even-parity bit is sent between
//                        the last data bit and the stop bit. When undefined
//                        the frame is plain 8N1 and no parity logic exists.
//
//   All outputs are registered.
module uart_tx_byte #(
    parameter int DATA_SIZE    = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_byte_if.slave     bus,
    output logic [2:0]        dbg_state
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_SIZE) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_SIZE-1:0] shift_reg;
    logic [DATA_SIZE-1:0] shift_next;
    logic                 tx_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 baud_last;
    logic                 bit_last;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    assign baud_last  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign bit_last   = (bit_cnt == BIT_W'(DATA_SIZE - 1));
    assign shift_next = shift_reg >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            // done is a single-cycle pulse; only the STOP exit raises it.
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (bus.valid && ready_q) begin
                        shift_reg <= bus.D;
`ifdef UART_TX_PARITY_EN
                        // Parity comes from the accepted byte, not live D.
                        parity_q  <= ^bus.D;
`endif
                        state     <= START;
                        tx_q      <= 1'b0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                        tx_q     <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_last) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx_q  <= parity_q;
`else
                            state <= STOP;
                            tx_q  <= 1'b1;
`endif
                        end else begin
                            // tx is registered, so it takes the bit that
                            // will sit in shift_reg[0] after this shift.
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                            shift_reg <= shift_next;
                            tx_q      <= shift_next[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        tx_q     <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_last) begin
                        // First IDLE cycle: ready returns together with done.
                        baud_cnt <= '0;
                        state    <= IDLE;
                        tx_q     <= 1'b1;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx_q     <= 1'b1;
                    ready_q  <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx    = tx_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign dbg_state = state;

endmodule

// File: doc/uart_tx_byte.md
Name: uart_tx_byte

Overview:
- Byte-wide UART transmitter that sits directly downstream of the word-to-byte serializer.
- Accepts one DATA_SIZE-bit byte per valid/ready handshake and drives it onto a single TX line: start bit, data bits LSB first, stop bit, 8N1 by default.
- Its ready/done outputs pace the serializer's shift enable, so a 32-bit word leaves the FPGA as four back-to-back UART frames.

Parameters:
- DATA_SIZE, 8, data bits per frame.
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- D  input  DATA_SIZE  byte to transmit; sampled only on an accepting edge.
- valid  input  1  D holds a byte to send.
- ready  output  1  block can accept a byte this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress, i.e. state != IDLE.
- done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Registered outputs: all outputs are registered.
- Reset values, and state after any rst edge: state=IDLE, tx=1, ready=1, busy=0, done=0, baud and bit counters=0.
- Accept rule: a byte is accepted on the edge where valid && ready.
  - D is latched into a shift register on that edge.
  - valid while ready=0 is ignored; there is no buffering.
  - D need not be held after acceptance.
- State machine: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
  - IDLE: tx=1, ready=1, busy=0. On accept, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx=shift_reg[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit, repeat DATA_SIZE times.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Counters:
  - Baud counter counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). It wraps to 0 at each bit boundary and advances state/bit at the terminal count.
  - Bit counter width is $clog2(DATA_SIZE)+1.
- Latency:
  - tx falls in the first cycle after the accepting edge.
  - Frame length on tx is (DATA_SIZE+2)*CLKS_PER_BIT cycles.
- done timing:
  - done=1 for exactly one cycle, the first cycle back in IDLE, coincident with ready returning to 1.
  - done is never asserted by reset.
- Back-to-back frames:
  - If valid is high in the done cycle, the next byte is accepted on that edge.
  - Minimum accept-to-accept spacing is therefore (DATA_SIZE+2)*CLKS_PER_BIT+1 cycles, including one idle-high cycle between frames.
- Reset mid-frame: the frame is aborted and the next cycle shows tx=1, ready=1, busy=0, done=0. No partial data is retained.
- Simultaneous rst and valid: rst wins and the byte is not accepted.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the accepted byte) for CLKS_PER_BIT cycles.
  - Frame length becomes (DATA_SIZE+3)*CLKS_PER_BIT.
  - Parity is computed from the byte latched at accept, not from live D.
- Undefined: no PARITY state, the frame is 8N1, and no parity logic is synthesized.

Test Plan:
- Reset check: hold rst 3 cycles with valid=1, D=8'hFF, then release -> tx=1, ready=1, busy=0, done=0 throughout, no frame starts during rst; the first accept occurs only after release.
- Single byte, CLKS_PER_BIT=4: send 8'hA5 -> from the cycle after accept, tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles). done pulses once on cycle 41 with ready=1, and busy=1 exactly on cycles 1-40.
- Back-to-back, CLKS_PER_BIT=4: hold valid=1, present 8'h00 then 8'hFF (switch D on the first accept) -> frame 1 data bits all 0, frame 2 data bits all 1. There is exactly one idle-high cycle between the stop bit and the next start bit, and accepts are 41 cycles apart.
- Valid while busy: pulse valid with D=8'h3C mid-frame of 8'h81 -> 8'h81 is transmitted unchanged, 8'h3C is never sent, and no extra done pulse occurs.
- Reset mid-frame: assert rst during data bit 3 of 8'h55 -> next cycle tx=1, ready=1, busy=0, done=0. A following 8'h0F transmits a complete, correct frame.
- Parity (UART_TX_PARITY_EN defined, CLKS_PER_BIT=4):
  - 8'hA5 -> parity bit 0, frame 44 cycles.
  - 8'h07 -> parity bit 1.
  - done arrives on cycle 45 after accept.
